bin2bcd_seq: RTL

Sequential binary-to-BCD converter using shift-add-3 (double-dabble), one bit per clock. It sits directly upstream of the 7-segment digit-select mux. It converts a binary account or amount value into eight packed BCD digits for the 32-bit digit bus, ones digit in bits [3:0]. The output register holds the last result stable between conversions, so the display scan never sees intermediate values.

---
 rtl/bin2bcd_seq_pkg.sv | 27 ++
 rtl/bin2bcd_seq_add3.sv | 15 +
 rtl/bin2bcd_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// ==== bin2bcd_seq_pkg : shared constants/types for the BCD converter | rev 1.0 ====
`default_nettype none

package bin2bcd_seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DIGITS_DEFAULT = 8;
  localparam int BCD_W_DEFAULT  = 4 * DIGITS_DEFAULT;

  // Largest value representable in d decimal digits (10^d - 1).
  function automatic logic [63:0] pow10_m1(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0]              BCD_MAX_DEFAULT   = pow10_m1(DIGITS_DEFAULT);
  localparam logic [BCD_W_DEFAULT-1:0] ALL_NINES_DEFAULT = {DIGITS_DEFAULT{4'h9}};

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
// ==== bcd_add3 : double-dabble digit correction cell (>=5 ? +3) | rev 1.0 ====
`default_nettype none

module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  always_comb begin
    adj = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ==== bin2bcd_seq : sequential shift-add-3 binary to packed BCD, 1 bit/clk | rev 1.0 ====
`default_nettype none

module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int                  BCD_W     = 4 * DIGITS;
  localparam int                  CNT_W     = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]    LAST      = CNT_W'(BIN_W - 1);
  localparam logic [63:0]         BCD_MAX   = pow10_m1(DIGITS);
  localparam logic [BCD_W-1:0]    ALL_NINES = {DIGITS{4'h9}};

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic               ovf_pending;
  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   shifted;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[4*k +: 4]),
      .adj   (adjusted[4*k +: 4])
    );
  end

  assign shifted = {adjusted[BCD_W-2:0], bin_sr[BIN_W-1]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bin_sr      <= '0;
      scratch     <= '0;
      ovf_pending <= 1'b0;
      bcd         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr      <= bin;
            scratch     <= '0;
            ovf_pending <= (64'(bin) > BCD_MAX);
            cnt         <= '0;
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          if (cnt == LAST) begin
            // Values beyond DIGITS digits saturate so the display never shows a truncated number.
            bcd  <= ovf_pending ? ALL_NINES : shifted;
            ovf  <= ovf_pending;
            done <= 1'b1;
            busy <= 1'b0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
